// File: rtl/jkff_seq_driver.sv
// rtl/jkff_seq_driver.sv - JK flip-flop pattern sequencer and checker
// Forces the flop to a start level, walks it through a bit pattern with J/K, and flags the first mismatch.
module jkff_seq_driver #(
    parameter int WIDTH      = 8,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       pat_in,
    input  logic                   init_q,
    input  logic                   start_valid,
    output logic                   start_ready,
    output logic                   j,
    output logic                   k,
    output logic                   pr_n,
    output logic                   cl_n,
    input  logic                   q_fb,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [$clog2(WIDTH):0] err_idx
);
    localparam int CW = $clog2(WIDTH);
    localparam int IW = CW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic           prev_q, prev_d;
    logic           j_q, j_d;
    logic           k_q, k_d;
    logic           pr_n_q, pr_n_d;
    logic           cl_n_q, cl_n_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [IW-1:0]  err_idx_q, err_idx_d;
    logic [IW-1:0]  run_fail_idx;

    function automatic logic [1:0] excite(input logic cur, input logic nxt);
        if (cur == nxt) begin
            return 2'b00;
        end else if (USE_TOGGLE) begin
            return 2'b11;
        end else begin
            return nxt ? 2'b10 : 2'b01;
        end
    endfunction

    // RUN step 0 checks the forced start level, reported as index WIDTH.
    assign run_fail_idx = (idx_q == '0) ? IW'(WIDTH) : ({1'b0, idx_q} - IW'(1));
    assign start_ready  = (state_q == S_IDLE) && !rst;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        idx_d     = idx_q;
        prev_d    = prev_q;
        j_d       = j_q;
        k_d       = k_q;
        pr_n_d    = pr_n_q;
        cl_n_d    = cl_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid && start_ready) begin
                    state_d   = S_INIT;
                    pat_d     = pat_in;
                    prev_d    = init_q;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    busy_d    = 1'b1;
                    j_d       = 1'b0;
                    k_d       = 1'b0;
                    pr_n_d    = ~init_q;
                    cl_n_d    = init_q;
                end
            end
            S_INIT: begin
                state_d    = S_RUN;
                idx_d      = '0;
                pr_n_d     = 1'b1;
                cl_n_d     = 1'b1;
                {j_d, k_d} = excite(prev_q, pat_q[0]);
            end
            S_RUN: begin
                if (!err_q && (q_fb != prev_q)) begin
                    err_d     = 1'b1;
                    err_idx_d = run_fail_idx;
                end
                // pat_q[0] is always the current step's target.
                prev_d = pat_q[0];
                pat_d  = pat_q >> 1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                end else begin
                    idx_d      = idx_q + CW'(1);
                    {j_d, k_d} = excite(pat_q[0], pat_q[1]);
                end
            end
            S_DRAIN: begin
                if (!err_q && (q_fb != prev_q)) begin
                    err_d     = 1'b1;
                    err_idx_d = IW'(WIDTH - 1);
                end
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            idx_q     <= '0;
            prev_q    <= 1'b0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            pr_n_q    <= 1'b1;
            cl_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            prev_q    <= prev_d;
            j_q       <= j_d;
            k_q       <= k_d;
            pr_n_q    <= pr_n_d;
            cl_n_q    <= cl_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign pr_n    = pr_n_q;
    assign cl_n    = cl_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_idx = err_idx_q;

endmodule
